// File: rtl/window_addr_pkg.sv
// window_addr_pkg: shared FSM type, default geometry and sizing helpers for window_addr_gen
package window_addr_pkg;
  typedef enum logic [0:0] {IDLE, SCAN} state_t;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 32;
  localparam int DEF_K = 3;
  localparam int DEF_STRIDE = 1;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int tap_w(input int k);
    return clog2(k) > 0 ? clog2(k) : 1;
  endfunction
  function automatic int nwin(input int len, input int k, input int s);
    return len < k ? 0 : (len - k) / s + 1;
  endfunction
  localparam int NCOL = nwin(DEF_IMG_W, DEF_K, DEF_STRIDE);
  localparam int NROW = nwin(DEF_IMG_H, DEF_K, DEF_STRIDE);
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: counter stepping by STEP on inc, returning to zero (with wrap) after reaching MAX
module wrap_counter #(
  parameter int W = 4,
  parameter int MAX = 3,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);
  assign wrap = inc && value == W'(MAX);
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (inc) value <= wrap ? '0 : value + W'(STEP);
endmodule

// File: rtl/window_addr_gen.sv
// window_addr_gen: scans a KxK sliding window over a row-major image, emitting K row addresses per beat
module window_addr_gen
  import window_addr_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K = DEF_K,
  parameter int STRIDE = DEF_STRIDE,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [K*ADDR_W-1:0]   addr,
  output logic                  valid,
  input  logic                  ready,
  output logic [tap_w(K)-1:0]   tap,
  output logic [ADDR_W-1:0]     win_col,
  output logic [ADDR_W-1:0]     win_row,
  output logic                  win_end,
  output logic                  last
);
  localparam int TW = tap_w(K);
  localparam bit EMPTY = IMG_W < K || IMG_H < K;
  localparam int CMAX = EMPTY ? 0 : (nwin(IMG_W, K, STRIDE) - 1) * STRIDE;
  localparam int RMAX = EMPTY ? 0 : (nwin(IMG_H, K, STRIDE) - 1) * STRIDE;
  localparam logic [ADDR_W-1:0] CSTEP = ADDR_W'(STRIDE - K + 1);
  localparam logic [ADDR_W-1:0] RSTEP = ADDR_W'(IMG_W * STRIDE);
  state_t state;
  logic acc, t_wrap, c_wrap, r_wrap;
  assign busy = state == SCAN;
  assign valid = busy;
  assign acc = valid && ready;
  assign win_end = valid && tap == TW'(K - 1);
  assign last = win_end && win_col == ADDR_W'(CMAX) && win_row == ADDR_W'(RMAX);
  wrap_counter #(.W(TW), .MAX(K - 1), .STEP(1)) u_t (
    .clk(clk), .rst(rst), .inc(acc), .value(tap), .wrap(t_wrap)
  );
  wrap_counter #(.W(ADDR_W), .MAX(CMAX), .STEP(STRIDE)) u_c (
    .clk(clk), .rst(rst), .inc(t_wrap), .value(win_col), .wrap(c_wrap)
  );
  wrap_counter #(.W(ADDR_W), .MAX(RMAX), .STEP(STRIDE)) u_r (
    .clk(clk), .rst(rst), .inc(c_wrap), .value(win_row), .wrap(r_wrap)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state == IDLE ? (start && !EMPTY ? SCAN : IDLE) : (acc && last ? IDLE : SCAN);
      done <= state == IDLE ? start && EMPTY : acc && last;
    end
  for (genvar i = 0; i < K; i++) begin : g_lane
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(i * IMG_W);
    logic [ADDR_W-1:0] rb, a;
    always_ff @(posedge clk)
      if (rst) begin
        rb <= R0;
        a <= R0;
      end else if (acc) begin
        rb <= r_wrap ? R0 : c_wrap ? rb + RSTEP : rb;
        a <= r_wrap ? R0 : c_wrap ? rb + RSTEP : t_wrap ? a + CSTEP : a + ADDR_W'(1);
      end
    assign addr[i*ADDR_W +: ADDR_W] = a;
  end
endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: randomized scan checks of window_addr_gen against an arithmetic window model
module tb_window_addr_gen;
  logic clk = 0, rst = 1, start = 0, ready = 0;
  int sel = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  logic b0, dn0, v0, we0, l0, b1, dn1, v1, we1, l1, b2, dn2, v2, we2, l2;
  logic [29:0] a0;
  logic [17:0] a1, a2;
  logic [1:0] tp0, tp1, tp2;
  logic [9:0] wc0, wr0;
  logic [5:0] wc1, wr1, wc2, wr2;
  logic busy_m, done_m, valid_m, we_m, last_m;
  logic [29:0] addr_m;
  logic [1:0] tap_m;
  logic [9:0] col_m, row_m;
  window_addr_gen u0 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .busy(b0), .done(dn0), .addr(a0), .valid(v0),
    .ready(ready && sel == 0), .tap(tp0), .win_col(wc0), .win_row(wr0), .win_end(we0), .last(l0)
  );
  window_addr_gen #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2), .ADDR_W(6)) u1 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .busy(b1), .done(dn1), .addr(a1), .valid(v1),
    .ready(ready && sel == 1), .tap(tp1), .win_col(wc1), .win_row(wr1), .win_end(we1), .last(l1)
  );
  window_addr_gen #(.IMG_W(2), .IMG_H(32), .K(3), .STRIDE(1), .ADDR_W(6)) u2 (
    .clk(clk), .rst(rst), .start(start && sel == 2), .busy(b2), .done(dn2), .addr(a2), .valid(v2),
    .ready(ready && sel == 2), .tap(tp2), .win_col(wc2), .win_row(wr2), .win_end(we2), .last(l2)
  );
  function automatic logic [29:0] widen(input logic [17:0] x);
    return {4'b0, x[17:12], 4'b0, x[11:6], 4'b0, x[5:0]};
  endfunction
  always_comb begin
    busy_m = sel == 0 ? b0 : sel == 1 ? b1 : b2;
    done_m = sel == 0 ? dn0 : sel == 1 ? dn1 : dn2;
    valid_m = sel == 0 ? v0 : sel == 1 ? v1 : v2;
    we_m = sel == 0 ? we0 : sel == 1 ? we1 : we2;
    last_m = sel == 0 ? l0 : sel == 1 ? l1 : l2;
    addr_m = sel == 0 ? a0 : sel == 1 ? widen(a1) : widen(a2);
    tap_m = sel == 0 ? tp0 : sel == 1 ? tp1 : tp2;
    col_m = sel == 0 ? wc0 : sel == 1 ? {4'b0, wc1} : {4'b0, wc2};
    row_m = sel == 0 ? wr0 : sel == 1 ? {4'b0, wr1} : {4'b0, wr2};
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [29:0] exp_addr(input int w, input int r, input int c, input int t);
    logic [29:0] e = '0;
    for (int i = 0; i < 3; i++) e[i*10 +: 10] = 10'((r + i) * w + c + t);
    return e;
  endfunction
  task automatic run(input int s, input int w, input int h, input int st, input int mode);
    int nc = (w - 3) / st + 1;
    int nr = (h - 3) / st + 1;
    int n = nc * nr * 3;
    int beat = 0, stall = 0, cyc = 0, t, c, r;
    bit restarted = 0;
    sel = s;
    start = 1;
    @(negedge clk);
    start = 0;
    while (beat < n && cyc < 20000) begin
      cyc++;
      t = beat % 3;
      c = (beat / 3 % nc) * st;
      r = (beat / 3 / nc) * st;
      if (!valid_m) begin
        chk("valid", valid_m, 1);
        break;
      end
      if (mode == 4 && beat == 500) begin
        rst = 1;
        start = 1;
        @(negedge clk);
        rst = 0;
        start = 0;
        chk("rst_valid", valid_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_addr", addr_m, exp_addr(w, 0, 0, 0));
        chk("rst_tap", tap_m, 0);
        chk("rst_col", col_m, 0);
        chk("rst_row", row_m, 0);
        chk("rst_flags", {done_m, we_m, last_m}, 0);
        @(negedge clk);
        chk("rst_start_dropped", valid_m, 0);
        return;
      end
      chk("busy", busy_m, 1);
      chk("done_mid", done_m, 0);
      chk("addr", addr_m, exp_addr(w, r, c, t));
      chk("tap", tap_m, t);
      chk("col", col_m, c);
      chk("row", row_m, r);
      chk("win_end", we_m, t == 2);
      chk("last", last_m, beat == n - 1);
      if (beat == n - 1)
        chk("final_addr", addr_m, s == 0 ? {10'd1023, 10'd991, 10'd959} : {10'd54, 10'd46, 10'd38});
      ready = mode == 1 ? $urandom_range(0, 3) != 0 : mode == 2 ? !(beat == 1 && stall < 5) : 1'b1;
      if (mode == 2 && beat == 1 && !ready) stall++;
      if (mode == 3 && beat == 100 && !restarted) begin
        start = 1;
        restarted = 1;
      end
      if (ready) beat++;
      @(negedge clk);
      start = 0;
    end
    ready = 0;
    chk("beats", beat, n);
    chk("done", done_m, 1);
    chk("valid_end", valid_m, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_valid", v0, 0);
    chk("reset_busy", b0, 0);
    chk("reset_addr", a0, {10'd64, 10'd32, 10'd0});
    chk("reset_flags", {dn0, we0, l0, tp0}, 0);
    run(0, 32, 32, 1, 0);
    @(negedge clk);
    chk("done_pulse", done_m, 0);
    chk("idle_valid", valid_m, 0);
    run(0, 32, 32, 1, 2);
    run(0, 32, 32, 1, 3);
    @(negedge clk);
    chk("done_pulse", done_m, 0);
    run(0, 32, 32, 1, 4);
    run(0, 32, 32, 1, 1);
    @(negedge clk);
    run(1, 8, 8, 2, 1);
    run(1, 8, 8, 2, 0);
    @(negedge clk);
    chk("done_pulse", done_m, 0);
    sel = 2;
    start = 1;
    ready = 1;
    @(negedge clk);
    start = 0;
    chk("empty_done", done_m, 1);
    chk("empty_valid", valid_m, 0);
    repeat (5) begin
      @(negedge clk);
      chk("empty_idle", {valid_m, done_m, busy_m}, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/window_addr_gen.md
Name: window_addr_gen

Overview:
- Parametrised successor to the fixed 32-column, 3-row image address register.
- Autonomously scans a K x K sliding window over an IMG_W x IMG_H row-major image with configurable stride.
- Each beat emits K read addresses, one per window row, to the triple/multi-port image RAM.
- Feeds the convolution datapath over a valid/ready handshake, with start/busy/done control toward the top-level sequencer.

Parameters:
- IMG_W, 32, image width in pixels (columns per row).
- IMG_H, 32, image height in pixels.
- K, 3, window size: rows per beat and column taps per window.
- STRIDE, 1, window step in both column and row directions.
- ADDR_W, 10, address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a full scan; honoured only in IDLE.
- busy  out  1  high in SCAN state.
- done  out  1  one-cycle pulse after the final beat is accepted.
- addr  out  K*ADDR_W  packed addresses; lane i (bits i*ADDR_W +: ADDR_W) is window row i.
- valid  out  1  addr/tap/win_end/last are meaningful.
- ready  in  1  downstream accepts the beat when valid && ready.
- tap  out  clog2(K)  column tap index t within the current window.
- win_col  out  ADDR_W  current window left column c.
- win_row  out  ADDR_W  current window top row r.
- win_end  out  1  high on the beat with t = K-1.
- last  out  1  high on the final beat of the final window.

Behaviour:
- Reset (rst=1 at clock edge, including mid-scan):
  - FSM goes to IDLE.
  - valid, busy, done, last and win_end go to 0; tap, win_col and win_row go to 0.
  - addr lane i resets to i*IMG_W.
  - Any in-flight beat is dropped.
- States:
  - IDLE: start=1 loads r=0, c=0, t=0 and moves to SCAN. valid rises the next cycle (1-cycle latency from start).
  - SCAN: valid=1 continuously. On accept (valid && ready), advance t. When t wraps, advance c by STRIDE. When c wraps, advance r by STRIDE.
  - SCAN to IDLE: on accept of the beat with last=1. done pulses in the cycle after that accept, coincident with valid=0.
- Counter rules:
  - t runs 0..K-1.
  - c runs 0, STRIDE, ... while c <= IMG_W-K; beyond that c wraps to 0 and r advances.
  - r runs 0, STRIDE, ... while r <= IMG_H-K.
  - Partial windows are never emitted.
- Address arithmetic: addr lane i = (r+i)*IMG_W + c + t.
  - Computed at ADDR_W bits with no truncation for legal parameters.
  - Outputs are registered; base terms are kept as incrementing row-base registers (add IMG_W*STRIDE per row step), not multipliers.
- Handshake:
  - valid && !ready freezes all outputs unchanged.
  - valid never drops in SCAN without an accept.
  - ready is ignored when valid=0.
- Flags are combinationally aligned with the registered beat:
  - win_end = (t == K-1).
  - last = win_end && c is the final column && r is the final row.
- Boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as rst: reset wins.
  - A new start in the cycle done pulses is accepted (FSM already in IDLE).
  - If IMG_W < K or IMG_H < K, start produces an immediate done pulse with no beats.

Decomposition:
- Package window_addr_pkg holds:
  - state enum (IDLE, SCAN);
  - a clog2 helper function;
  - derived localparams NCOL = (IMG_W-K)/STRIDE+1 and NROW = (IMG_H-K)/STRIDE+1.
- Sub-module wrap_counter is natural: parametrised MAX and STEP, with inc input, wrap output and value output. It is instanced three times, for t, c and r, chained by their wrap outputs.
- The K-lane address adder is a generate loop in the top module.

Test Plan:
- Defaults, ready=1, start pulse:
  - beats 0..2 give addr (0,32,64), (1,33,65), (2,34,66), tap 0..2, win_end on beat 2;
  - beat 3 gives (1,33,65) with win_col=1;
  - exactly 2700 beats in total;
  - final beat (959,991,1023) with last=1; done pulses one cycle later.
- IMG_W=8, IMG_H=8, K=3, STRIDE=2:
  - 27 beats;
  - window origins c,r in {0,2,4};
  - final beat (38,46,54) with last=1.
- Backpressure: ready=0 for 5 cycles at beat 1 -> valid stays 1 and addr holds (1,33,65) all 5 cycles; beat 2 follows the first cycle with ready=1; total beat count unchanged.
- start re-asserted at beat 100 while busy -> ignored; scan completes normally with 2700 beats and a single done pulse.
- rst asserted at beat 500 -> next cycle valid=0, busy=0, addr=(0,32,64); a subsequent start restarts from (0,32,64).
- IMG_W=2 with K=3 -> start yields a done pulse on the next cycle, valid never asserted.
